// File: rtl/write_buffer_pkg.sv
// Shared definitions for the store write buffer: default depth, drain-FSM
// state encodings, the buffered entry layout and the byte-merge helper.
package write_buffer_pkg;

    // Default number of buffered word writes (power of two, >= 2).
    localparam int WB_DEPTH_DEFAULT = 4;

    // Drain FSM state encodings.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_LO = 2'd2;
    localparam logic [1:0] ST_WAIT_HI = 2'd3;

    // One buffered store: word address, data and byte strobes.
    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wb_entry_t;

    // Overwrite the bytes of old_data whose strobe is set with new_data.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_data,
        input logic [31:0] new_data,
        input logic [3:0]  strb
    );
        logic [31:0] result;
        result = old_data;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[8*b +: 8] = new_data[8*b +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/write_buffer.sv
// Store write buffer between the CPU store port and the AXI write master.
// Holds up to DEPTH word stores in FIFO order, merges a store into the tail
// entry when it targets the same word, flags load hazards against every held
// entry and drains the head through a four-state request/response handshake.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic        aclk,
    input  logic        areset,

    // CPU store port
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_waddr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_wrdy,
    output logic        wb_empty,

    // Load hazard check
    input  logic [31:0] hz_addr,
    output logic        hz_hit,

    // Drain port toward the AXI master
    output logic [3:0]  dc_cpu_wen,
    output logic [31:0] dc_cpu_waddr,
    output logic [31:0] dc_cpu_wdata,
    input  logic        dc_dev_wrdy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // Storage and bookkeeping
    wb_entry_t        entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W:0]   count;
    logic [1:0]       state;

    // Datapath decisions for this cycle
    logic [PTR_W-1:0] last_ptr;
    logic             push;
    logic             pop;
    logic             tail_is_head;
    logic             merge_ok;
    logic             do_merge;
    logic             do_append;
    wb_entry_t        merged_entry;
    wb_entry_t        head_view;

    // Address low bits are byte offsets inside the word and never compared.
    logic unused_low_bits;
    assign unused_low_bits = ^{cpu_waddr[1:0], hz_addr[1:0]};

    // Status outputs come straight from the registered count.
    assign cpu_wrdy = (count < FULL_COUNT);
    assign wb_empty = (count == '0);

    assign push      = (cpu_wen != 4'h0) && cpu_wrdy;
    assign pop       = (state == ST_WAIT_HI) && dc_dev_wrdy;
    assign last_ptr  = tail_ptr - PTR_ONE;

    // Decide between merging into the tail entry and appending a new entry.
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        tail_is_head = (count == COUNT_ONE);
        merge_ok     = 1'b0;
        if (count != '0) begin
            // The in-flight head is frozen once the drain has started.
            merge_ok = (entry_q[last_ptr].addr == cpu_waddr[31:2]) &&
                       !(tail_is_head && (state != ST_IDLE));
        end
        do_merge  = push && merge_ok;
        do_append = push && !merge_ok;

        merged_entry      = entry_q[last_ptr];
        merged_entry.strb = entry_q[last_ptr].strb | cpu_wen;
        merged_entry.data = merge_bytes(entry_q[last_ptr].data, cpu_wdata, cpu_wen);
    end

    // Head entry as it will look after this edge, so a merge into an idle head
    // on the issue edge is not lost from the outgoing request.
    always_comb begin
        head_view = entry_q[head_ptr];
        if (do_merge && (last_ptr == head_ptr)) begin
            head_view = merged_entry;
        end
    end

    // Entry payload storage: append at the tail slot or merge into the last one.
    // NOTE: the payload array carries no reset; valid_q alone decides whether a
    // slot is held, so clearing the data words would only cost reset fan-out.
    always_ff @(posedge aclk) begin
        if (do_append) begin
            entry_q[tail_ptr] <= '{addr: cpu_waddr[31:2], data: cpu_wdata, strb: cpu_wen};
        end else if (do_merge) begin
            entry_q[last_ptr] <= merged_entry;
        end
    end

    // Per-slot valid flags: set on append, cleared when the head is popped.
    // NOTE: clocked state uses non-blocking assignments so every always_ff
    // samples the pre-edge values regardless of evaluation order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_ptr] <= 1'b0;
            end
            if (do_append) begin
                valid_q[tail_ptr] <= 1'b1;
            end
        end
    end

    // Head/tail pointers wrap naturally at DEPTH; count tracks held entries.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_append) begin
                tail_ptr <= tail_ptr + PTR_ONE;
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_ONE;
            end
            case ({do_append, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Drain FSM with registered request outputs toward the AXI master.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state        <= ST_IDLE;
            dc_cpu_wen   <= 4'h0;
            dc_cpu_waddr <= 32'h0;
            dc_cpu_wdata <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state        <= ST_ISSUE;
                        dc_cpu_wen   <= head_view.strb;
                        dc_cpu_waddr <= {head_view.addr, 2'b00};
                        dc_cpu_wdata <= head_view.data;
                    end
                end
                ST_ISSUE: begin
                    // Request accepted; ready drops next cycle.
                    if (dc_dev_wrdy) begin
                        state      <= ST_WAIT_LO;
                        dc_cpu_wen <= 4'h0;
                    end
                end
                ST_WAIT_LO: begin
                    if (!dc_dev_wrdy) begin
                        state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // Ready rising again is the write response; head pops here.
                    if (dc_dev_wrdy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dc_cpu_wen <= 4'h0;
                end
            endcase
        end
    end

    // Load hazard: any held entry whose word address matches the load.
    always_comb begin
        hz_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entry_q[i].addr == hz_addr[31:2])) begin
                hz_hit = 1'b1;
            end
        end
    end

endmodule
